pipe_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. Operands are split into SEG-bit segments, and one segment of the carry chain is resolved per pipeline stage. This gives one result per clock at WIDTH/SEG cycles latency, with a valid/ready handshake on both sides. It is the datapath add/sub primitive that the multiplier and accumulator blocks instantiate in place of fixed 8-bit ripple adders.

---
 rtl/pipe_addsub_if.sv | 27 ++
 rtl/pipe_addsub.sv | 97 +++++++++
 tb/tb_pipe_addsub.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_addsub_if.sv
// Operand/result channel of pipe_addsub: operand beat in, result beat out, each with valid/ready.
// The slave side belongs to the adder; the master side to whoever feeds and drains it.
interface pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
endinterface

// File: rtl/pipe_addsub.sv
// Segmented carry-pipelined add/sub: one SEG-bit carry segment per stage, WIDTH/SEG cycles latency.
// Whole pipe advances only when the output slot is free or drained; a stall freezes every stage.
module pipe_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave io
);
  localparam int STAGES = WIDTH / SEG;

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             c0;

  assign adv         = !io.out_valid || io.out_ready;
  assign io.in_ready = adv;
  assign bx          = io.sub ? ~io.b : io.b;
  assign c0          = io.cin ^ io.sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SEG;
    localparam int HI = WIDTH - (k + 1) * SEG;

    logic                   vld_d, vld_q;
    logic                   c_d, c_q;
    logic [(k+1)*SEG-1:0]   sum_d, sum_q;
    logic [WIDTH-LO-1:0]    in_a, in_b;
    logic                   seg_c;
    logic [SEG:0]           seg_r;

    if (k == 0) begin : g_head
      assign vld_d = io.in_valid;
      assign in_a  = io.a;
      assign in_b  = bx;
      assign seg_c = c0;
      assign sum_d = seg_r[SEG-1:0];
    end else begin : g_body
      assign vld_d = g_stg[k-1].vld_q;
      assign in_a  = g_stg[k-1].g_op.a_q;
      assign in_b  = g_stg[k-1].g_op.bx_q;
      assign seg_c = g_stg[k-1].c_q;
      assign sum_d = {seg_r[SEG-1:0], g_stg[k-1].sum_q};
    end

    assign seg_r = {1'b0, in_a[SEG-1:0]} + {1'b0, in_b[SEG-1:0]} + {{SEG{1'b0}}, seg_c};
    assign c_d   = seg_r[SEG];

    // Data only moves with a real beat, so bubbles and idle inputs never disturb s/cout/ovf.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        if (vld_d) begin
          c_q   <= c_d;
          sum_q <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_op
      logic [HI-1:0] a_q, bx_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (adv && vld_d) begin
          a_q  <= in_a[WIDTH-LO-1:SEG];
          bx_q <= in_b[WIDTH-LO-1:SEG];
        end
      end
    end else begin : g_tail
      logic ovf_d, ovf_q;

      // Carry-in and carry-out of the MSB differ exactly when equal-signed operands flip the sign.
      assign ovf_d = (in_a[SEG-1] == in_b[SEG-1]) && (seg_r[SEG-1] != in_a[SEG-1]);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && vld_d) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign io.out_valid = g_stg[STAGES-1].vld_q;
  assign io.s         = g_stg[STAGES-1].sum_q;
  assign io.cout      = g_stg[STAGES-1].c_q;
  assign io.ovf       = g_stg[STAGES-1].g_tail.ovf_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and streaming checks of pipe_addsub at 16/4 and 8/8 against an arithmetic reference.
module tb_pipe_addsub;
  logic clk = 1'b0;
  logic rst_n;
  bit   rdy_mode;
  int   total = 0;
  int   bad   = 0;
  logic [17:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(16)) i16 ();
  pipe_addsub_if #(.WIDTH(8))  i8 ();

  pipe_addsub #(.WIDTH(16), .SEG(4)) u16 (.clk(clk), .rst_n(rst_n), .io(i16));
  pipe_addsub #(.WIDTH(8),  .SEG(8)) u8  (.clk(clk), .rst_n(rst_n), .io(i8));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {ovf, cout, s} from integer arithmetic: signed range for ovf, unsigned range for carry/borrow.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sub, input logic cin);
    int ia, ib, ua, ub, sr, ur;
    logic [15:0] s;
    logic c, o;
    ia = int'($signed(a));
    ib = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    if (sub) begin
      sr = ia - ib - int'(cin);
      ur = ua - ub - int'(cin);
      c  = (ur >= 0);
    end else begin
      sr = ia + ib + int'(cin);
      ur = ua + ub + int'(cin);
      c  = (ur > 65535);
    end
    o = (sr > 32767) || (sr < -32768);
    s = ur[15:0];
    return {o, c, s};
  endfunction

  // Scoreboard on the 16-bit instance: push on acceptance, pop on retirement, hold during stalls.
  initial begin
    logic        prev_stall;
    logic [17:0] prev_out;
    logic [17:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", 32'(i16.out_valid), 32'd1);
          chk("stall_data", 32'({i16.ovf, i16.cout, i16.s}), 32'(prev_out));
        end
        if (i16.in_valid && i16.in_ready)
          exp_q.push_back(model16(i16.a, i16.b, i16.sub, i16.cin));
        if (i16.out_valid && i16.out_ready) begin
          chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("stream_result", 32'({i16.ovf, i16.cout, i16.s}), 32'(e));
          end
        end
        prev_stall = i16.out_valid && !i16.out_ready;
        prev_out   = {i16.ovf, i16.cout, i16.s};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      i16.out_ready = rdy_mode ? 1'($urandom) : 1'b1;
    end
  end

  // One isolated beat: checks latency, result, a single-cycle out_valid pulse, and pins the model.
  task automatic beat(input bit w8, input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic cin, input logic [15:0] es,
                      input logic ec, input logic eo, input string nm);
    int n;
    logic [15:0] rs;
    logic rc, ro, rv;
    if (w8) begin
      i8.a = a[7:0]; i8.b = b[7:0]; i8.sub = sub; i8.cin = cin; i8.in_valid = 1'b1;
    end else begin
      i16.a = a; i16.b = b; i16.sub = sub; i16.cin = cin; i16.in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    i8.in_valid  = 1'b0;
    i16.in_valid = 1'b0;
    n = 0;
    rv = w8 ? i8.out_valid : i16.out_valid;
    while (!rv && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      rv = w8 ? i8.out_valid : i16.out_valid;
    end
    chk({nm, "_latency"}, 32'(n), w8 ? 32'd0 : 32'd3);
    rs = w8 ? {8'h00, i8.s} : i16.s;
    rc = w8 ? i8.cout : i16.cout;
    ro = w8 ? i8.ovf : i16.ovf;
    chk({nm, "_s"}, 32'(rs), 32'(es));
    chk({nm, "_cout"}, 32'(rc), 32'(ec));
    chk({nm, "_ovf"}, 32'(ro), 32'(eo));
    if (!w8) chk({nm, "_model"}, 32'(model16(a, b, sub, cin)), 32'({eo, ec, es}));
    @(posedge clk);
    #1;
    chk({nm, "_pulse"}, 32'(w8 ? i8.out_valid : i16.out_valid), 32'd0);
  endtask

  initial begin
    int  n;
    bit  acc;
    int  cnt;
    rst_n = 1'b0;
    rdy_mode = 1'b0;
    i16.in_valid = 1'b0; i16.a = '0; i16.b = '0; i16.sub = 1'b0; i16.cin = 1'b0;
    i16.out_ready = 1'b1;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.sub = 1'b0; i8.cin = 1'b0;
    i8.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid16", 32'(i16.out_valid), 32'd0);
    chk("rst_in_ready16", 32'(i16.in_ready), 32'd1);
    chk("rst_data16", 32'({i16.ovf, i16.cout, i16.s}), 32'd0);
    chk("rst_out_valid8", 32'(i8.out_valid), 32'd0);
    chk("rst_data8", 32'({i8.ovf, i8.cout, i8.s}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    beat(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
    beat(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    beat(1'b0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
    beat(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
    beat(1'b0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, "sub_borrow_cin");
    beat(1'b0, 16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2234, 1'b0, 1'b0, "add_cin");

    // Back-to-back random beats under random backpressure.
    rdy_mode = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i16.a = 16'($urandom); i16.b = 16'($urandom);
      i16.sub = 1'($urandom); i16.cin = 1'($urandom);
      i16.in_valid = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        acc = i16.in_ready;
        @(posedge clk);
        #1;
        n++;
      end while (!acc && n < 200);
      chk("stream_accept", 32'(acc), 32'd1);
    end
    i16.in_valid = 1'b0;
    rdy_mode = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("stream_drain", 32'(exp_q.size()), 32'd0);

    // Reset with three beats in flight, before any reaches the output.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      i16.a = 16'h1111 * 16'(i + 1); i16.b = 16'h0101; i16.sub = 1'b0; i16.cin = 1'b1;
      i16.in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    i16.in_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_out_valid", 32'(i16.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(i16.in_ready), 32'd1);
    chk("midrst_data", 32'({i16.ovf, i16.cout, i16.s}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (i16.out_valid) cnt++;
    end
    chk("midrst_no_stale", 32'(cnt), 32'd0);

    beat(1'b0, 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "post_rst_add");

    beat(1'b1, 16'h0080, 16'h0080, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "w8_add_ovf");
    beat(1'b1, 16'h007F, 16'h0001, 1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, "w8_pos_ovf");
    beat(1'b1, 16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000F, 1'b1, 1'b0, "w8_sub");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end
endmodule
